// File: rtl/regfile_wb_arbiter_pkg.sv
// Register-file geometry shared by the writeback arbiter, its sub-blocks and its interface.
package regfile_wb_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bundle: requester side (master) drives req_*, arbiter side (slave) drives the
// registered write port, the per-requester ready and the in-flight register mask.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 2
);

    logic [NUM_REQ-1:0]                                   req_valid;
    logic [NUM_REQ*regfile_wb_arbiter_pkg::REG_IDX_W-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0]                            req_data;
    logic [NUM_REQ-1:0]                                   req_ready;
    logic [regfile_wb_arbiter_pkg::REG_IDX_W-1:0]         WR_REG;
    logic                                                 wr_en;
    logic [DATA_W-1:0]                                    wr_data;
    logic [IDX_W-1:0]                                     grant_id;
    logic [regfile_wb_arbiter_pkg::NUM_REGS-1:0]          pending_mask;

    modport master (
        output req_valid, req_reg, req_data,
        input  req_ready, WR_REG, wr_en, wr_data, grant_id, pending_mask
    );

    modport slave (
        input  req_valid, req_reg, req_data,
        output req_ready, WR_REG, wr_en, wr_data, grant_id, pending_mask
    );

endinterface

// File: rtl/decoder_five.sv
// 5-bit register index to 32-bit one-hot, gated by en; purely combinational.
// No handshake: output follows inputs in the same cycle.
module decoder_five (
    input  logic [4:0]  idx,
    input  logic        en,
    output logic [31:0] onehot
);

    assign onehot = en ? (32'd1 << idx) : 32'd0;

endmodule

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr, wrapping to the bottom.
// Combinational (0 cycles); no backpressure, grant is zero when no request is asserted.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic found;

    // Two passes: upper slice [ptr..NUM_REQ-1] has priority over the wrapped slice [0..ptr-1].
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback requesters, round-robin.
// Latency 1 cycle fire->wr_en; losers see req_ready=0 and must hold their request.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 2
) (
    input  logic                clock,
    input  logic                reset,
    regfile_wb_arbiter_if.slave bus
);

    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  ready;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    next_ptr;
    logic                fire;
    reg_idx_t            sel_reg;
    logic [DATA_W-1:0]   sel_data;

    reg_idx_t            wr_reg_q;
    logic                wr_en_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [IDX_W-1:0]    grant_id_q;

    logic [NUM_REGS-1:0] dec_req [NUM_REQ];
    logic [NUM_REGS-1:0] dec_port;
    logic [NUM_REGS-1:0] mask;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign ready    = reset ? '0 : grant;
    assign fire     = |(bus.req_valid & ready);
    assign next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

    always_comb begin
        sel_reg  = REG_ZERO;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_reg  = bus.req_reg[i*REG_IDX_W +: REG_IDX_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A $r0 request is consumed and rotates priority but never raises wr_en.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_reg_q   <= REG_ZERO;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
            rr_ptr     <= '0;
        end else begin
            wr_en_q <= fire && (sel_reg != REG_ZERO);
            if (fire) begin
                wr_reg_q   <= sel_reg;
                wr_data_q  <= sel_data;
                grant_id_q <= grant_idx;
                rr_ptr     <= next_ptr;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_dec
        decoder_five u_dec (
            .idx    (bus.req_reg[g*REG_IDX_W +: REG_IDX_W]),
            .en     (bus.req_valid[g]),
            .onehot (dec_req[g])
        );
    end

    decoder_five u_dec_port (
        .idx    (wr_reg_q),
        .en     (wr_en_q),
        .onehot (dec_port)
    );

    always_comb begin
        mask = dec_port;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask = mask | dec_req[i];
        end
        mask[REG_ZERO] = 1'b0;
    end

    assign bus.req_ready    = ready;
    assign bus.WR_REG       = wr_reg_q;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.pending_mask = mask;

endmodule
